// File: rtl/dot_scroll_scanner.sv
// Row-scanning driver for an active-low-row LED dot matrix with a scroll-in/rotate pattern buffer.
// Optional DOT_BLANK_EN: blank rows/columns for BLANK_CYC cycles after each scan tick (anti-ghosting).

module dot_scroll_row #(
    parameter int COLS = 16,
    parameter int KW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      op,
    input  logic            dir,
    input  logic [KW-1:0]   shamt,
    input  logic [COLS-1:0] pat,
    output logic [COLS-1:0] disp
);
    localparam logic [1:0] OP_HOLD  = 2'd0;
    localparam logic [1:0] OP_CLR   = 2'd1;
    localparam logic [1:0] OP_ENTER = 2'd2;
    localparam logic [1:0] OP_ROT   = 2'd3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp <= '0;
        end else begin
            case (op)
                OP_CLR:   disp <= '0;
                OP_ENTER: disp <= dir ? (pat >> shamt) : (pat << shamt);
                OP_ROT:   disp <= dir ? {disp[COLS-2:0], disp[COLS-1]}
                                      : {disp[0], disp[COLS-1:1]};
                OP_HOLD:  disp <= disp;
                default:  disp <= disp;
            endcase
        end
    end
endmodule

module dot_scroll_scanner #(
    parameter int ROWS      = 8,
    parameter int COLS      = 16,
    parameter int SCAN_DIV  = 5000,
    parameter int STEP_DIV  = 6250000,
    parameter int BLANK_CYC = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_data,
    input  logic                    load,
    input  logic                    run,
    input  logic                    dir,
    output logic [ROWS-1:0]         dot_row,
    output logic [COLS-1:0]         dot_col,
    output logic [1:0]              state_o,
    output logic                    enter_done
);
    localparam int RW = $clog2(ROWS);
    localparam int KW = $clog2(COLS);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int TW = $clog2(STEP_DIV);

    localparam logic [1:0] OP_HOLD  = 2'd0;
    localparam logic [1:0] OP_CLR   = 2'd1;
    localparam logic [1:0] OP_ENTER = 2'd2;
    localparam logic [1:0] OP_ROT   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENTER  = 2'd1,
        S_ROTATE = 2'd2
    } state_t;

    state_t                     state, state_nxt;
    logic [KW-1:0]              k, k_nxt;
    logic                       done_nxt;
    logic [1:0]                 op;
    logic [KW-1:0]              shamt;
    logic [SW-1:0]              scan_cnt;
    logic [TW-1:0]              step_cnt;
    logic                       scan_tick, step_tick;
    logic [RW-1:0]              row_idx;
    logic                       wr_ok;
    logic [ROWS-1:0][COLS-1:0]  pattern;
    logic [ROWS-1:0][COLS-1:0]  display;

    function automatic logic [ROWS-1:0] row_sel(input logic [RW-1:0] idx);
        logic [RW-1:0] pos;
        pos = RW'(ROWS-1) - idx;
        row_sel = '1;
        row_sel[pos] = 1'b0;
    endfunction

    // ---------------- prescalers ----------------
    assign scan_tick = (scan_cnt == SW'(SCAN_DIV-1));
    assign step_tick = run && (step_cnt == TW'(STEP_DIV-1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            step_cnt <= '0;
            row_idx  <= '0;
        end else begin
            scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
            if (run)
                step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
            if (scan_tick)
                row_idx <= (row_idx == RW'(ROWS-1)) ? '0 : row_idx + 1'b1;
        end
    end

    // ---------------- pattern buffer ----------------
    assign wr_ok = ({{(32-RW){1'b0}}, wr_row} < 32'(ROWS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pattern <= '0;
        else if (wr_en && wr_ok)
            pattern[wr_row] <= wr_data;
    end

    // ---------------- scroll FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            k          <= '0;
            enter_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            k          <= k_nxt;
            enter_done <= done_nxt;
        end
    end

    // load outranks a coincident step so the restart always begins from blank
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        done_nxt  = 1'b0;
        op        = OP_HOLD;
        if (load) begin
            state_nxt = S_ENTER;
            k_nxt     = '0;
            op        = OP_CLR;
        end else if (step_tick) begin
            case (state)
                S_ENTER: begin
                    op = OP_ENTER;
                    if (k == KW'(COLS-1)) begin
                        state_nxt = S_ROTATE;
                        k_nxt     = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        k_nxt = k + 1'b1;
                    end
                end
                S_ROTATE: op = OP_ROT;
                default:  op = OP_HOLD;
            endcase
        end
    end

    assign shamt   = KW'(COLS-1) - k;
    assign state_o = state;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        dot_scroll_row #(
            .COLS (COLS),
            .KW   (KW)
        ) u_row (
            .clk   (clk),
            .rst   (rst),
            .op    (op),
            .dir   (dir),
            .shamt (shamt),
            .pat   (pattern[r]),
            .disp  (display[r])
        );
    end

    // ---------------- row/column drive ----------------
`ifdef DOT_BLANK_EN
    localparam int BW = $clog2(BLANK_CYC+1);
    logic [BW-1:0]   blank_cnt;
    logic [ROWS-1:0] pend_row;
    logic [COLS-1:0] pend_col;

    // row data is captured at the tick and released when the blank interval expires
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dot_row   <= '1;
            dot_col   <= '0;
            pend_row  <= '1;
            pend_col  <= '0;
            blank_cnt <= '0;
        end else if (scan_tick) begin
            dot_row   <= '1;
            dot_col   <= '0;
            pend_row  <= row_sel(row_idx);
            pend_col  <= display[row_idx];
            blank_cnt <= BW'(BLANK_CYC);
        end else if (blank_cnt != '0) begin
            blank_cnt <= blank_cnt - 1'b1;
            if (blank_cnt == BW'(1)) begin
                dot_row <= pend_row;
                dot_col <= pend_col;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dot_row <= '1;
            dot_col <= '0;
        end else if (scan_tick) begin
            dot_row <= row_sel(row_idx);
            dot_col <= display[row_idx];
        end
    end
`endif

endmodule

// File: tb/tb_dot_scroll_scanner.sv
// Directed bench for dot_scroll_scanner: ROWS=8, COLS=16, SCAN_DIV=4, STEP_DIV=10, BLANK_CYC=2.

module tb_dot_scroll_scanner;
    localparam int ROWS = 8;
    localparam int COLS = 16;
`ifdef DOT_BLANK_EN
    localparam int BLK = 2;
`else
    localparam int BLK = 0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en;
    logic [2:0]      wr_row;
    logic [15:0]     wr_data;
    logic            load, run, dir;
    logic [7:0]      dot_row;
    logic [15:0]     dot_col;
    logic [1:0]      state_o;
    logic            enter_done;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    typedef struct {
        logic [2:0]  row;
        logic [15:0] data;
        logic [7:0]  exp_row;
    } vec_t;
    vec_t tbl [8];

    dot_scroll_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .STEP_DIV(10), .BLANK_CYC(2)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .load(load), .run(run), .dir(dir), .dot_row(dot_row), .dot_col(dot_col),
        .state_o(state_o), .enter_done(enter_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (enter_done === 1'b1) done_cnt++;
        end
    endtask

    // exactly n step ticks; the step prescaler ends back at 0
    task automatic steps(input int n);
        run = 1'b1;
        cyc(10 * n);
        run = 1'b0;
    endtask

    task automatic wr(input logic [2:0] r, input logic [15:0] d);
        wr_en = 1'b1; wr_row = r; wr_data = d;
        cyc(1);
        wr_en = 1'b0;
    endtask

    task automatic pulse_load();
        load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    // wait for a fresh start of row r being driven
    task automatic wait_row(input logic [7:0] r, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (dot_row !== r) break;
            cyc(1);
        end
        for (int i = 0; i < 80; i++) begin
            if (dot_row === r) begin ok = 1'b1; break; end
            cyc(1);
        end
    endtask

    task automatic chk_row0(input string nm, input logic [15:0] exp);
        bit ok;
        wait_row(8'h7F, ok);
        if (!ok) chk({nm, "_timeout"}, 32'd0, 32'd1);
        else     chk(nm, dot_col, exp);
    endtask

    initial begin
        bit ok;
        tbl[0] = '{3'd0, 16'h1234, 8'h7F};
        tbl[1] = '{3'd1, 16'h5A5A, 8'hBF};
        tbl[2] = '{3'd2, 16'h00FF, 8'hDF};
        tbl[3] = '{3'd3, 16'h8001, 8'hEF};
        tbl[4] = '{3'd4, 16'hF0F0, 8'hF7};
        tbl[5] = '{3'd5, 16'h0F0F, 8'hFB};
        tbl[6] = '{3'd6, 16'hC3C3, 8'hFD};
        tbl[7] = '{3'd7, 16'h7E7E, 8'hFE};

        rst = 1'b0; wr_en = 1'b0; wr_row = '0; wr_data = '0;
        load = 1'b0; run = 1'b0; dir = 1'b0;
        cyc(3);
        chk("rst_row", dot_row, 8'hFF);
        chk("rst_col", dot_col, 16'h0);
        chk("rst_state", state_o, 2'd0);
        chk("rst_done", enter_done, 1'b0);
        rst = 1'b1;

        // 1: reset in the middle of ENTER
        wr(3'd0, 16'hC908);
        pulse_load();
        chk("load_state", state_o, 2'd1);
        steps(5);
        run = 1'b1;
        cyc(3);
        rst = 1'b0;
        #1;
        chk("midrst_row", dot_row, 8'hFF);
        chk("midrst_col", dot_col, 16'h0);
        chk("midrst_state", state_o, 2'd0);
        cyc(1);
        rst = 1'b1; run = 1'b0;
        cyc(3 + BLK);
        chk("post_rst_idle_row", dot_row, 8'hFF);
        cyc(1);
        chk("post_rst_first_row", dot_row, 8'h7F);
        chk("post_rst_first_col", dot_col, 16'h0);

        // 2: scroll-in, dir=0
        wr(3'd0, 16'hC908);
        pulse_load();
        done_cnt = 0;
        steps(1);
        chk_row0("enter_step1", 16'h0000);
        steps(3);
        chk_row0("enter_step4", 16'h8000);
        chk("enter_state", state_o, 2'd1);
        steps(12);
        chk("enter_done_cnt", done_cnt, 1);
        chk("rotate_state", state_o, 2'd2);
        chk_row0("enter_step16", 16'hC908);

        // 3: rotation both directions
        steps(1);
        chk_row0("rot_right", 16'h6484);
        dir = 1'b1;
        steps(2);
        chk_row0("rot_left2", 16'h9211);

        // 5a: pause holds display and state
        cyc(100);
        chk_row0("pause_hold", 16'h9211);
        chk("pause_state", state_o, 2'd2);

        // 4: scan order with a full pattern
        dir = 1'b0;
        for (int i = 0; i < 8; i++) wr(tbl[i].row, tbl[i].data);
        pulse_load();
        done_cnt = 0;
        steps(16);
        chk("scan_state", state_o, 2'd2);
        chk("scan_done_cnt", done_cnt, 1);
        wait_row(8'h7F, ok);
        if (!ok) chk("scan_sync_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("scan_row%0d", i), dot_row, tbl[i].exp_row);
            chk($sformatf("scan_col%0d", i), dot_col, tbl[i].data);
            cyc(4);
        end
        chk("scan_wrap", dot_row, 8'h7F);

`ifdef DOT_BLANK_EN
        // 6: blank interval after each scan tick
        cyc(1);
        chk("blank_pre", dot_row, 8'h7F);
        cyc(1);
        chk("blank_row1", dot_row, 8'hFF);
        chk("blank_col1", dot_col, 16'h0);
        cyc(1);
        chk("blank_row2", dot_row, 8'hFF);
        cyc(1);
        chk("blank_next", dot_row, 8'hBF);
`else
        cyc(3);
        chk("noblank_hold", dot_row, 8'h7F);
        cyc(1);
        chk("noblank_next", dot_row, 8'hBF);
`endif

        // 5b: load coincident with step_tick
        done_cnt = 0;
        run = 1'b1;
        cyc(9);
        load = 1'b1;
        cyc(1);
        load = 1'b0; run = 1'b0;
        chk("load_vs_step_state", state_o, 2'd1);
        wait_row(8'h7F, ok);
        if (!ok) chk("clr_sync_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("clr_col%0d", i), dot_col, 16'h0);
            cyc(4);
        end
        chk("load_vs_step_done", done_cnt, 0);

        // write and load in the same cycle: first step uses the new data
        wr_en = 1'b1; wr_row = 3'd0; wr_data = 16'h0001; load = 1'b1;
        cyc(1);
        wr_en = 1'b0; load = 1'b0;
        steps(1);
        chk_row0("wr_load_same", 16'h8000);

        // dir=1 scroll-in enters at the LSB
        wr(3'd0, 16'h8000);
        dir = 1'b1;
        pulse_load();
        steps(1);
        chk_row0("enter_dir1", 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dot_scroll_scanner.md
Name: dot_scroll_scanner

Overview:
- Parametrised row-scanning driver for an active-low-row LED dot matrix of ROWS x COLS, with a writable pattern buffer.
- On a load pulse, the stored pattern scrolls into an initially blank display one column per step. After that it rotates continuously, in either direction.
- Sits between the game/pattern logic and the matrix pins.
- All timing comes from single-cycle enables derived from clk; no derived clocks.

Parameters:
- ROWS, 8, number of matrix rows (>=2).
- COLS, 16, number of matrix columns (>=2).
- SCAN_DIV, 5000, clk cycles per row-scan tick (>=2).
- STEP_DIV, 6250000, clk cycles per scroll-step tick (>=2).
- BLANK_CYC, 16, blanking length in clk cycles; used only with DOT_BLANK_EN (< SCAN_DIV).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- wr_en  in  1  pattern buffer write strobe.
- wr_row  in  $clog2(ROWS)  pattern row written.
- wr_data  in  COLS  pattern row data; 1 = LED on.
- load  in  1  one-cycle pulse: restart the scroll-in from blank.
- run  in  1  1 = scroll steps advance; 0 = pause.
- dir  in  1  0 = content enters at MSB and rotates right; 1 = content enters at LSB and rotates left.
- dot_row  out  ROWS  active-low row select, one-hot low.
- dot_col  out  COLS  column data for the selected row.
- state_o  out  2  scroll state: 0 IDLE, 1 ENTER, 2 ROTATE.
- enter_done  out  1  one-cycle pulse when ENTER completes.

Behaviour:
- Reset (async, rst=0), applied at any time including mid-scroll:
  - dot_row = all ones; dot_col = 0.
  - Pattern buffer = 0; display registers = 0.
  - state = IDLE; step index k = 0; row index = 0; both prescalers = 0; enter_done = 0.
- Scan prescaler:
  - Counts 0..SCAN_DIV-1 and wraps; scan_tick asserts on the count SCAN_DIV-1, i.e. once every SCAN_DIV cycles.
  - Scanning always runs, independent of run and state.
- On scan_tick (registered, visible the next cycle):
  - dot_col <= display[row_idx].
  - dot_row <= all ones except bit ROWS-1-row_idx = 0. Row 0 drives the MSB low.
  - row_idx increments, wrapping ROWS-1 -> 0.
- Step prescaler:
  - Advances only while run=1; holds its value while run=0.
  - step_tick asserts on count STEP_DIV-1, then the count wraps to 0.
- Pattern writes:
  - wr_en writes pattern[wr_row] <= wr_data in any state.
  - wr_row >= ROWS is ignored.
  - A write does not touch the display directly.
  - During ENTER the display is computed from the live pattern, so a write takes effect from the next step.
- FSM:
  - IDLE: display held. load -> ENTER with k=0 and display cleared to 0 in that cycle.
  - ENTER, on step_tick:
    - dir=0: display[r] <= pattern[r] << (COLS-1-k); the low k+1 pattern bits appear at the top.
    - dir=1: display[r] <= pattern[r] >> (COLS-1-k).
    - Then k++. At k=COLS-1 the display equals the pattern; go to ROTATE, k <= 0, enter_done pulses for 1 cycle.
  - ROTATE, on step_tick: each row rotates by 1 bit.
    - dir=0: {bit0, bits[COLS-1:1]}.
    - dir=1: {bits[COLS-2:0], bit MSB}.
  - load in any state restarts ENTER from blank.
- Simultaneous events:
  - load and step_tick in the same cycle: load wins; no step is applied.
  - wr_en and load in the same cycle: the write is committed; the first ENTER step uses the new data.
  - dir changes take effect at the next step_tick.

Optional Feature:
- Macro: DOT_BLANK_EN.
- Defined (anti-ghosting):
  - On each scan_tick, dot_row <= all ones and dot_col <= 0.
  - Exactly BLANK_CYC cycles later, the new row and column data are driven.
  - row_idx still advances on the scan_tick.
- Undefined: the new row is driven the cycle after scan_tick, with no blank interval and no extra logic.

Test Plan:
- Bench parameters for all scenarios: ROWS=8, COLS=16, SCAN_DIV=4, STEP_DIV=10.
1. Reset: drive rst=0 mid-ENTER (k=5) -> dot_row=8'hFF, dot_col=0, state_o=0 immediately. After release, the first scan drives dot_row=8'h7F with dot_col=0.
2. Scroll-in, dir=0: write pattern[0]=16'hC908, pulse load, run=1. After step 1, display[0]=16'h0000 (bit0 of 16'hC908 is 0). After step 4, display[0]=16'h8000. After 16 steps, display[0]=16'hC908, enter_done pulses once, state_o=2.
3. Rotation: from scenario 2, dir=0, one step -> display[0]=16'h6484. Set dir=1, two steps -> 16'h9211.
4. Scan order: fill the pattern and run to ROTATE. dot_row then cycles 7F, BF, DF, EF, F7, FB, FD, FE, 7F at 4-cycle spacing, with dot_col matching display rows 0..7.
5. Pause and priority: run=0 for 100 cycles -> display and k unchanged. load coincident with step_tick -> state_o=1, display all 0.
6. DOT_BLANK_EN, BLANK_CYC=2: after each scan_tick, dot_row=8'hFF for exactly 2 cycles, then the selected row is driven.
